// File: rtl/quadrature_step_generator.sv
// Quadrature A/B generator: walks a virtual 8-bit position to a commanded
// target along the shortest path around the wrap, one Gray transition per step period.
module quadrature_step_generator #(
   parameter int PHASES_PER_COUNT = 4,
   parameter int PERIOD_W         = 16
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic [7:0]          target,
   input  logic [PERIOD_W-1:0] step_period,
   input  logic                load,
   input  logic                pause,
   output logic                enc_a,
   output logic                enc_b,
   output logic [7:0]          position,
   output logic                busy,
   output logic                done
);

   if (PHASES_PER_COUNT != 1 && PHASES_PER_COUNT != 2 && PHASES_PER_COUNT != 4) begin : g_bad_phases
      $error("PHASES_PER_COUNT must be 1, 2 or 4");
   end

   localparam logic [1:0]          SUB_LAST   = 2'(PHASES_PER_COUNT - 1);
   localparam logic [PERIOD_W-1:0] PERIOD_ONE = PERIOD_W'(1);

   typedef enum logic {IDLE, RUN} state_t;

   state_t              state, state_n;
   logic [1:0]          phase, phase_n;
   logic [PERIOD_W-1:0] cnt, cnt_n;
   logic [1:0]          sub, sub_n;
   logic [7:0]          pos_n;
   logic [7:0]          target_q, target_n;
   logic [PERIOD_W-1:0] period_q, period_n;
   logic                inc_q, inc_n;
   logic                done_n;

   // Shortest path around the wrap; the 128 tie resolves to increment.
   function automatic logic dir_up(input logic [7:0] diff);
      return (diff != 8'd0) && (diff <= 8'd128);
   endfunction

   // Phase index 0..3 maps to {A,B} = 00,10,11,01 so +1 steps make A lead.
   function automatic logic [1:0] phase_to_ab(input logic [1:0] p);
      case (p)
         2'd0:    return 2'b00;
         2'd1:    return 2'b10;
         2'd2:    return 2'b11;
         default: return 2'b01;
      endcase
   endfunction

   function automatic logic [PERIOD_W-1:0] eff_period(input logic [PERIOD_W-1:0] p);
      return (p == '0) ? PERIOD_ONE : p;
   endfunction

   assign busy = (state == RUN);

   always_comb begin
      state_n  = state;
      phase_n  = phase;
      cnt_n    = cnt;
      sub_n    = sub;
      pos_n    = position;
      target_n = target_q;
      period_n = period_q;
      inc_n    = inc_q;
      done_n   = 1'b0;
      case (state)
         IDLE: begin
            if (load) begin
               if (target == position) begin
                  done_n = 1'b1;
               end else begin
                  state_n  = RUN;
                  target_n = target;
                  period_n = eff_period(step_period);
                  cnt_n    = '0;
                  sub_n    = '0;
                  inc_n    = dir_up(target - position);
               end
            end
         end
         RUN: begin
            // A retarget only changes the destination; the count in flight keeps its direction.
            if (load) begin
               target_n = target;
               period_n = eff_period(step_period);
            end
            if (!pause) begin
               if (cnt >= period_q - PERIOD_ONE) begin
                  cnt_n   = '0;
                  phase_n = inc_q ? phase + 2'd1 : phase - 2'd1;
                  if (sub == SUB_LAST) begin
                     sub_n = '0;
                     pos_n = inc_q ? position + 8'd1 : position - 8'd1;
                     if (pos_n == target_n) begin
                        state_n = IDLE;
                        done_n  = 1'b1;
                     end else begin
                        inc_n = dir_up(target_n - pos_n);
                     end
                  end else begin
                     sub_n = sub + 2'd1;
                  end
               end else begin
                  cnt_n = cnt + PERIOD_ONE;
               end
            end
         end
         default: state_n = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= IDLE;
         phase    <= '0;
         cnt      <= '0;
         sub      <= '0;
         position <= '0;
         target_q <= '0;
         period_q <= PERIOD_ONE;
         inc_q    <= 1'b1;
         done     <= 1'b0;
         enc_a    <= 1'b0;
         enc_b    <= 1'b0;
      end else begin
         state          <= state_n;
         phase          <= phase_n;
         cnt            <= cnt_n;
         sub            <= sub_n;
         position       <= pos_n;
         target_q       <= target_n;
         period_q       <= period_n;
         inc_q          <= inc_n;
         done           <= done_n;
         {enc_a, enc_b} <= phase_to_ab(phase_n);
      end
   end

endmodule
